// File: rtl/irq_arb.sv
// rtl/irq_arb.sv - fixed-priority N-channel interrupt arbiter for the 65C02 control path
// Edge/level, maskable/non-maskable channels; one take per sync, held off until done.
module irq_arb #(
  parameter int         N         = 2,
  parameter logic [7:0] NMI_MASK  = 8'h01,
  parameter logic [7:0] EDGE_MASK = 8'h01,
  parameter logic [7:0] VEC_BASE  = 8'hFA,
  parameter logic [7:0] VEC_STEP  = 8'h04
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq_in,
  input  logic         I,
  input  logic         sync,
  input  logic         rdy,
  input  logic         done,
  output logic         take,
  output logic         busy,
  output logic [2:0]   src,
  output logic [7:0]   vec,
  output logic [N-1:0] pend
);

  localparam logic [N-1:0] NMI = NMI_MASK[N-1:0];
  localparam logic [N-1:0] EDG = EDGE_MASK[N-1:0];

  typedef enum logic {IDLE = 1'b0, SERV = 1'b1} state_t;
  state_t state, state_nxt;

  logic [N-1:0] prev, latch, request, eligible, clr;
  logic [2:0]   win;
  logic         any;

  assign request  = (EDG & latch) | (~EDG & irq_in);
  assign eligible = request & (NMI | {N{~I}});
  assign any      = |eligible;
  assign pend     = latch;

  // Scan downwards so the lowest-index eligible channel is the last assignment.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (eligible[k]) win = 3'(k);
  end

  always_comb begin
    clr = '0;
    for (int k = 0; k < N; k++)
      clr[k] = take && (win == 3'(k));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SERV;
      SERV:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SERV);
    take = (state == IDLE) && any && sync && rdy;
  end

  // prev resets high so a line already asserted at reset release is not seen as an edge;
  // a fresh rising edge in the consuming cycle re-sets the latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev  <= '1;
      latch <= '0;
      src   <= '0;
      vec   <= VEC_BASE;
    end else begin
      prev  <= irq_in;
      latch <= EDG & ((irq_in & ~prev) | (latch & ~clr));
      if (take) begin
        src <= win;
        vec <= VEC_BASE + 8'(win) * VEC_STEP;
      end
    end
  end

endmodule

// File: doc/irq_arb.md
# irq_arb

Parametrised interrupt arbiter for the 65C02 core control path. It generalises the single NMI edge latch and IRQ gate to N interrupt channels, each configured as maskable or non-maskable and as edge- or level-sensitive. It arbitrates by fixed priority and presents a take request to the control FSM at instruction sync. It latches the winning channel's vector low byte for the BRK/IRQ sequence and holds off further takes until the core signals that the vector fetch is done.

## Interface
- N, 2: number of interrupt channels, 1..8; channel 0 is highest priority.
- NMI_MASK, 2'b01: bit k=1 makes channel k non-maskable (ignores I).
- EDGE_MASK, 2'b01: bit k=1 makes channel k rising-edge sensitive; 0 makes it level sensitive.
- VEC_BASE, 8'hFA: vector low byte for channel 0.
- VEC_STEP, 8'h04: vector spacing; channel k vector = VEC_BASE + k*VEC_STEP, mod 256 (defaults give FA, FE).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  N  interrupt lines, synchronous to clk, active high.
- I  in  1  processor interrupt-disable flag.
- sync  in  1  core is in opcode-fetch cycle.
- rdy  in  1  core ready; sync is only honoured when rdy=1.
- done  in  1  one-cycle pulse from the core when the interrupt vector has been fetched.
- take  out  1  combinational; an interrupt will be taken at this sync.
- busy  out  1  interrupt sequence in progress (state SERV).
- src  out  3  registered index of the channel being serviced.
- vec  out  8  registered vector low byte of the channel being serviced.
- pend  out  N  registered edge-latch status, for debug.

## Operation
- Edge channel k: prev[k] <= irq_in[k] every cycle. The latch sets when irq_in[k] & ~prev[k].
- Edge channel k latch clears when channel k is consumed at a take. If a new rising edge arrives in the same cycle as the clear, set wins and the edge is kept.
- Level channel k: request[k] = irq_in[k] with no storage. pend[k] always reads 0.
- Edge channel: request[k] = latch[k].
- eligible[k] = request[k] & (NMI_MASK[k] | ~I).
- Winner = lowest-index eligible channel.
- take = (state==IDLE) & |eligible & sync & rdy.
- State machine, two states:
  - IDLE: on take, register src <= winner and vec <= VEC_BASE + winner*VEC_STEP (8-bit wrap), clear the winner's edge latch, go to SERV.
  - SERV: busy=1 and take=0. sync&rdy is ignored, so there is no nesting and the latch is not consumed. On done go to IDLE.
- done while in IDLE is ignored.
- Maskable edge events arriving while I=1 stay latched and are taken once I=0.
- A level request that drops before sync is lost, with no latching. A level request that drops after take does not abort SERV.
- Masked/non-maskable status is evaluated on the cycle of take only.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, src=0, vec=VEC_BASE, pend=0.
  - prev = all ones, so a line already high at release does not fire.
  - Reset mid-SERV aborts the sequence immediately.
- Edge latency: a rising edge sampled at clock edge t gives pend[k]=1 and makes the channel eligible from cycle t+1.
- Level latency: zero; take follows irq_in combinationally within the sync cycle.
- take is combinational. src, vec and busy update at the clock edge ending the take cycle and are valid from the next cycle until the next take.
- SERV to IDLE: busy falls at the clock edge that samples done=1. take can assert at the very next sync&rdy cycle.
- rdy=0 during sync: no take and no state change. Pending edges persist.
- src is zero-extended from ceil(log2 N) bits to 3 bits.

## Test plan
- **Edge NMI:** N=2 defaults, I=1. Pulse irq_in[0] for 1 cycle, then sync&rdy two cycles later -> take=1, next cycle busy=1, src=0, vec=8'hFA, pend[0]=0. Pulse done -> busy=0.
- **Mask:** I=1, irq_in[1]=1 (level) at sync&rdy -> take=0. Drop I -> take=1 at the next sync, vec=8'hFE, src=1.
- **Priority and simultaneity:** rising edge on ch0 and level on ch1 together, I=0 -> first take src=0. After done, the next sync gives src=1. A second ch0 edge on the same cycle as its take-clear -> pend[0] stays 1 and ch0 is taken again after done.
- **No nesting / rdy:** in SERV raise a ch0 edge with sync&rdy pulsed -> take=0, pend[0]=1. With rdy=0 at sync -> take=0. After done, take=1 at the first sync&rdy.
- **Reset:** assert reset mid-SERV -> busy=0, vec=8'hFA, pend=0 asynchronously. Hold irq_in[0]=1 through the release -> no take.
- **Parametrised:** N=4, NMI_MASK=4'b0011, EDGE_MASK=4'b0101, VEC_STEP=8'h04 -> ch3 vec = 8'h06 (wrap). I=1 blocks ch2/ch3 only.
